// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and a unified single-ported RAM.
// The master modport is the environment (core + RAM); the slave modport is the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 8
);
    logic                  imem_read_in;
    logic [ADDR_WIDTH-1:0] imem_read_addr_in;
    logic [DATA_WIDTH-1:0] imem_read_data_out;
    logic                  imem_valid_out;
    logic                  imem_stall_out;

    logic                  dmem_write_in;
    logic [ADDR_WIDTH-1:0] dmem_write_addr_in;
    logic [DATA_WIDTH-1:0] dmem_write_data_in;
    logic [MASK_WIDTH-1:0] dmem_write_mask_in;
    logic                  dmem_read_in;
    logic [ADDR_WIDTH-1:0] dmem_read_addr_in;
    logic [DATA_WIDTH-1:0] dmem_read_data_out;
    logic                  dmem_valid_out;
    logic                  dmem_stall_out;

    logic                  mem_write_out;
    logic [ADDR_WIDTH-1:0] mem_write_addr_out;
    logic [DATA_WIDTH-1:0] mem_write_data_out;
    logic [MASK_WIDTH-1:0] mem_write_mask_out;
    logic                  mem_read_out;
    logic [ADDR_WIDTH-1:0] mem_read_addr_out;
    logic [DATA_WIDTH-1:0] mem_read_data_in;

    modport master (
        output imem_read_in, imem_read_addr_in,
        input  imem_read_data_out, imem_valid_out, imem_stall_out,
        output dmem_write_in, dmem_write_addr_in, dmem_write_data_in, dmem_write_mask_in,
        output dmem_read_in, dmem_read_addr_in,
        input  dmem_read_data_out, dmem_valid_out, dmem_stall_out,
        input  mem_write_out, mem_write_addr_out, mem_write_data_out, mem_write_mask_out,
        input  mem_read_out, mem_read_addr_out,
        output mem_read_data_in
    );

    modport slave (
        input  imem_read_in, imem_read_addr_in,
        output imem_read_data_out, imem_valid_out, imem_stall_out,
        input  dmem_write_in, dmem_write_addr_in, dmem_write_data_in, dmem_write_mask_in,
        input  dmem_read_in, dmem_read_addr_in,
        output dmem_read_data_out, dmem_valid_out, dmem_stall_out,
        output mem_write_out, mem_write_addr_out, mem_write_data_out, mem_write_mask_out,
        output mem_read_out, mem_read_addr_out,
        input  mem_read_data_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, 1-cycle-latency RAM between instruction fetch and data access.
// Store beats load beats fetch, except a fetch starved MAX_STARVE cycles is forced through.
module mem_port_arbiter #(
    parameter int unsigned MAX_STARVE = 4
) (
    input logic          clk,
    input logic          reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} owner_e;

    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                force_fetch;
    logic                grant_fetch, grant_store, grant_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OwnNone;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        grant_fetch = 1'b0;
        grant_store = 1'b0;
        grant_load  = 1'b0;
        force_fetch = bus.imem_read_in && (starve_q == STARVE_MAX);
        if (!reset) begin
            if (force_fetch)            grant_fetch = 1'b1;
            else if (bus.dmem_write_in) grant_store = 1'b1;
            else if (bus.dmem_read_in)  grant_load  = 1'b1;
            else if (bus.imem_read_in)  grant_fetch = 1'b1;
        end
    end

    always_comb begin
        bus.mem_write_out      = grant_store;
        bus.mem_write_addr_out = grant_store ? bus.dmem_write_addr_in : '0;
        bus.mem_write_data_out = grant_store ? bus.dmem_write_data_in : '0;
        bus.mem_write_mask_out = grant_store ? bus.dmem_write_mask_in : '0;
        bus.mem_read_out       = grant_fetch || grant_load;
        bus.mem_read_addr_out  = '0;
        if (grant_load)       bus.mem_read_addr_out = bus.dmem_read_addr_in;
        else if (grant_fetch) bus.mem_read_addr_out = bus.imem_read_addr_in;

        // A data request is stalled unless every part of it (store and/or load) is served now.
        bus.imem_stall_out = !reset && bus.imem_read_in && !grant_fetch;
        bus.dmem_stall_out = !reset && ((bus.dmem_write_in && !grant_store) ||
                                        (bus.dmem_read_in && !grant_load));
    end

    always_comb begin
        owner_d = OwnNone;
        if (grant_fetch)     owner_d = OwnInstr;
        else if (grant_load) owner_d = OwnData;

        starve_d = starve_q;
        if (!bus.imem_read_in || grant_fetch) starve_d = '0;
        else if (starve_q != STARVE_MAX)      starve_d = starve_q + STARVE_W'(1);
    end

    // Returned data is dropped while reset is high so an in-flight read never reaches a port.
    always_comb begin
        bus.imem_valid_out     = !reset && (owner_q == OwnInstr);
        bus.dmem_valid_out     = !reset && (owner_q == OwnData);
        bus.imem_read_data_out = bus.imem_valid_out ? bus.mem_read_data_in : '0;
        bus.dmem_read_data_out = bus.dmem_valid_out ? bus.mem_read_data_in : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors against a behavioural RAM,
// plus hand sequences for fetch starvation and reset with a read in flight.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_STARVE(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // RAM model: unwritten words read as a fixed address-derived pattern.
    logic [31:0] ram [256];
    bit          written [256];
    logic [31:0] rdata = '0;

    assign bus.mem_read_data_in = rdata;

    function automatic logic [31:0] word_at(logic [31:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [7:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_write_out) begin
            ram[bus.mem_write_addr_out[9:2]] <= merge(
                written[bus.mem_write_addr_out[9:2]] ? ram[bus.mem_write_addr_out[9:2]]
                                                     : word_at(bus.mem_write_addr_out),
                bus.mem_write_data_out, bus.mem_write_mask_out);
            written[bus.mem_write_addr_out[9:2]] <= 1'b1;
        end
        if (bus.mem_read_out)
            rdata <= written[bus.mem_read_addr_out[9:2]] ? ram[bus.mem_read_addr_out[9:2]]
                                                        : word_at(bus.mem_read_addr_out);
    end

    task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic drive(logic ir, logic [31:0] ia, logic dw, logic [31:0] dwa, logic [31:0] dwd,
                         logic [7:0] dwm, logic dr, logic [31:0] dra);
        bus.imem_read_in       = ir;
        bus.imem_read_addr_in  = ia;
        bus.dmem_write_in      = dw;
        bus.dmem_write_addr_in = dwa;
        bus.dmem_write_data_in = dwd;
        bus.dmem_write_mask_in = dwm;
        bus.dmem_read_in       = dr;
        bus.dmem_read_addr_in  = dra;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dw;
        logic [31:0] dwa;
        logic [31:0] dwd;
        logic [7:0]  dwm;
        logic        dr;
        logic [31:0] dra;
        logic        mw;
        logic        mr;
        logic [31:0] mra;
        logic        ist;
        logic        dst;
        logic        iv;
        logic        dv;
        logic [31:0] rd;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        // ir ia  dw dwa dwd dwm  dr dra | mw mr mra  ist dst iv dv rd
        vecs[0]  = '{1'b1, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h4,   1'b0, 1'b0, 1'b1, 1'b0, word_at(32'h0)};
        vecs[2]  = '{1'b1, 32'h8,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 1'b1, 1'b0, word_at(32'h4)};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, word_at(32'h8)};
        vecs[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,  32'h0,        8'h00, 1'b1, 32'h200,
                     1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h100, 1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, word_at(32'h200)};
        vecs[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, word_at(32'h100)};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 32'h40, 32'h11223344, 8'h0F, 1'b1, 32'h40,
                     1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b1, 32'h40,
                     1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h11223344};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 32'h44, 32'hDEADBEEF, 8'h0F, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 32'h44, 32'h00000000, 8'h03, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b1, 32'h44,
                     1'b0, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 32'h0,  32'h0,        8'h00, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD0000};

        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h200);
        @(negedge clk);
        check("reset_mem_read", 0, 32'(bus.mem_read_out), 32'h0);
        check("reset_stalls", 0, 32'({bus.imem_stall_out, bus.dmem_stall_out}), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dw, vecs[i].dwa, vecs[i].dwd, vecs[i].dwm,
                  vecs[i].dr, vecs[i].dra);
            @(negedge clk);
            check("mem_write",      i, 32'(bus.mem_write_out), 32'(vecs[i].mw));
            check("mem_write_addr", i, bus.mem_write_addr_out, vecs[i].mw ? vecs[i].dwa : 32'h0);
            check("mem_write_data", i, bus.mem_write_data_out, vecs[i].mw ? vecs[i].dwd : 32'h0);
            check("mem_write_mask", i, 32'(bus.mem_write_mask_out),
                  vecs[i].mw ? 32'(vecs[i].dwm) : 32'h0);
            check("mem_read",       i, 32'(bus.mem_read_out), 32'(vecs[i].mr));
            check("mem_read_addr",  i, bus.mem_read_addr_out, vecs[i].mra);
            check("imem_stall",     i, 32'(bus.imem_stall_out), 32'(vecs[i].ist));
            check("dmem_stall",     i, 32'(bus.dmem_stall_out), 32'(vecs[i].dst));
            check("imem_valid",     i, 32'(bus.imem_valid_out), 32'(vecs[i].iv));
            check("dmem_valid",     i, 32'(bus.dmem_valid_out), 32'(vecs[i].dv));
            check("imem_data",      i, bus.imem_read_data_out, vecs[i].iv ? vecs[i].rd : 32'h0);
            check("dmem_data",      i, bus.dmem_read_data_out, vecs[i].dv ? vecs[i].rd : 32'h0);
            next_cycle();
        end

        // Two starved cycles, then a fetch-idle cycle which must clear the starvation count.
        repeat (2) begin
            drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h20);
            @(negedge clk);
            check("prefix_imem_stall", 0, 32'(bus.imem_stall_out), 32'h1);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        next_cycle();

        // Fetch held against stores then loads: every 5th cycle the fetch is forced through.
        for (int i = 0; i < 10; i++) begin
            bit forced;
            forced = (i % 5) == 4;
            if (i < 5) drive(1'b1, 32'h10, 1'b1, 32'h80, 32'h5555AAAA, 8'h0F, 1'b0, 32'h0);
            else       drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h20);
            @(negedge clk);
            check("starve_mem_write", i, 32'(bus.mem_write_out), 32'(i < 5 && !forced));
            check("starve_mem_read", i, 32'(bus.mem_read_out), 32'(forced || i >= 5));
            check("starve_read_addr", i, bus.mem_read_addr_out,
                  forced ? 32'h10 : (i < 5 ? 32'h0 : 32'h20));
            check("starve_imem_stall", i, 32'(bus.imem_stall_out), 32'(!forced));
            check("starve_dmem_stall", i, 32'(bus.dmem_stall_out), 32'(forced));
            check("starve_imem_valid", i, 32'(bus.imem_valid_out), 32'(i == 5));
            if (i == 5) check("starve_imem_data", i, bus.imem_read_data_out, word_at(32'h10));
            next_cycle();
        end

        // Reset lands the cycle after a load grant: the returning word must be discarded.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h200);
        @(negedge clk);
        check("rst_load_addr", 0, bus.mem_read_addr_out, 32'h200);
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_dmem_valid", 1, 32'(bus.dmem_valid_out), 32'h0);
        check("rst_dmem_data", 1, bus.dmem_read_data_out, 32'h0);
        check("rst_mem_read", 1, 32'(bus.mem_read_out), 32'h0);
        check("rst_imem_stall", 1, 32'(bus.imem_stall_out), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valids", 2, 32'({bus.imem_valid_out, bus.dmem_valid_out}), 32'h0);
        check("post_rst_mem_read", 2, 32'(bus.mem_read_out), 32'h1);
        check("post_rst_read_addr", 2, bus.mem_read_addr_out, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);
        @(negedge clk);
        check("post_rst_imem_valid", 3, 32'(bus.imem_valid_out), 32'h1);
        check("post_rst_imem_data", 3, bus.imem_read_data_out, word_at(32'h0));
        check("post_rst_dmem_valid", 3, 32'(bus.dmem_valid_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
